ram_arbiter: RTL
================

# ram_arbiter

Two-port round-robin arbiter that shares one `single_port_ram` instance between two independent requesters. It accepts at most one read or write command per cycle through valid/ready handshakes and registers the winning command onto the RAM port. It returns each result, read data or write echo, to the originating requester with a fixed latency. It sits directly in front of the RAM wherever two datapath agents need the same buffer.

## Interface
- `DATA_WIDTH`, 8, data width; must match the RAM.
- `RAM_DEPTH`, 1024, number of RAM words.
- `ADDR_WIDTH`, `$clog2(RAM_DEPTH)`, address width.

- `clk`  in  1  single clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `reqN_valid`  in  1  command from requester N (N = 0, 1).
- `reqN_ready`  out  1  command accepted this cycle.
- `reqN_we`  in  1  1 = write, 0 = read.
- `reqN_addr`  in  ADDR_WIDTH  word address.
- `reqN_wdata`  in  DATA_WIDTH  write data.
- `rspN_valid`  out  1  one-cycle response strobe to requester N.
- `rspN_rdata`  out  DATA_WIDTH  read data, or echoed write data.
- `ram_we`  out  1  to RAM `write_enable`.
- `ram_addr`  out  ADDR_WIDTH  to RAM `address`.
- `ram_wdata`  out  DATA_WIDTH  to RAM `data_in`.
- `ram_rdata`  in  DATA_WIDTH  from RAM `data_out`, registered inside the RAM.

## Operation
- Grant is combinational: `reqN_ready` = 1 only for the granted port, and at most one ready is high per cycle. Ready is 0 while `rst_n` = 0.
- Only one port valid: that port is granted.
- Both ports valid: the port named by priority pointer `prio` is granted.
- `prio` state, PRIO0 or PRIO1:
  - Resets to PRIO0.
  - After any accept on port k, `prio` moves to the other port.
  - No accept leaves `prio` unchanged.
- A command is accepted when `reqN_valid & reqN_ready` at a clock edge.
- Stage C (command register): on accept, load `ram_we`, `ram_addr`, `ram_wdata`, set `c_vld`, and record `c_port` = k.
  - With no accept: `c_vld` = 0 and `ram_we` = 0.
  - `ram_addr` and `ram_wdata` hold their last values.
- Stage R (RAM access): the RAM samples the stage C outputs; `r_vld` and `r_port` follow `c_vld` and `c_port`.
- Stage O (response): `rsp<r_port>_valid` = `r_vld`, and `rsp<r_port>_rdata` is loaded from `ram_rdata`.
  - A write returns the written data, because the RAM writes through to `data_out`.
  - `rspN_rdata` holds its value when no response is issued for port N.
- There is no response backpressure; requesters must sink `rspN_valid` every cycle.
- Responses return in acceptance order, and full throughput is one command per cycle.
- Commands never reorder. A read accepted on the cycle after a write to the same address returns the new data.

## Timing
- Accept at edge E0.
- RAM command is visible after E0.
- RAM samples at E1.
- `rspN_valid` and `rspN_rdata` are valid after E2 and high for exactly one cycle.
- Latency: 2 cycles from accept edge to response, for both reads and writes.
- Back-to-back accepts give back-to-back responses with no bubbles.
- Reset values: `ram_we` = 0, `ram_addr` = 0, `ram_wdata` = 0, `rspN_valid` = 0, `rspN_rdata` = 0, internal valids = 0, `prio` = PRIO0.
- Reset mid-operation: all in-flight commands and responses are dropped with no response issued. RAM contents are not cleared.
- Address wrap: none; `ADDR_WIDTH` bits are passed through unchanged.

## Configuration
- `RAM_ARB_FIXED_PRIO_EN` defined: port 0 always wins when both ports are valid. `prio` is not implemented, and port 1 may starve.
- `RAM_ARB_FIXED_PRIO_EN` undefined (default): round-robin as described above.

## Test plan
- Single read: preload addr 0x010 = 0xA5. `req0` reads 0x010 → `req0_ready` = 1 same cycle, `rsp0_valid` = 1 with 0xA5 two edges later, `rsp1_valid` stays 0.
- Write then read: `req1` writes 0x3FF ← 0x5C, next cycle `req1` reads 0x3FF → responses 0x5C (echo) and 0x5C on consecutive cycles.
- Contention: both ports hold valid for 4 cycles, reading 0x001 (=0x11) and 0x002 (=0x22) → grants 0,1,0,1 and responses 0x11, 0x22, 0x11, 0x22 routed to ports 0,1,0,1.
- Fixed priority: same stimulus with `RAM_ARB_FIXED_PRIO_EN` defined → 4 grants to port 0, `req1_ready` = 0 throughout.
- Reset mid-flight: accept a read, assert `rst_n` = 0 one cycle later → no `rspN_valid`, all outputs 0, `prio` = PRIO0. After release, RAM data written before reset is still readable.
- Idle: no valids for 10 cycles → `ram_we` = 0, no responses, `prio` unchanged.

Source files
------------

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two requesters, 2-cycle response latency.
// Define RAM_ARB_FIXED_PRIO_EN to make port 0 always win on contention (no priority pointer).
module ram_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RAM_DEPTH  = 1024,
    parameter int unsigned ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    logic grant0;
    logic grant1;
    logic accept;
    logic sel;
    logic c_vld;
    logic c_port;
    logic r_vld;
    logic r_port;

`ifndef RAM_ARB_FIXED_PRIO_EN
    typedef enum logic {PRIO0 = 1'b0, PRIO1 = 1'b1} prio_t;
    prio_t prio;
`endif

    // Combinational grant; nothing is granted while in reset.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            grant0 = req0_valid;
            grant1 = req1_valid & ~req0_valid;
`else
            if (req0_valid && req1_valid) begin
                grant0 = (prio == PRIO0);
                grant1 = (prio == PRIO1);
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
`endif
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign accept     = grant0 | grant1;
    assign sel        = grant1;

`ifndef RAM_ARB_FIXED_PRIO_EN
    // Priority pointer moves to the port that did not just win.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= PRIO0;
        end else if (accept) begin
            prio <= sel ? PRIO0 : PRIO1;
        end
    end
`endif

    // Stage C: register the winning command onto the RAM port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_vld     <= 1'b0;
            c_port    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            c_vld  <= accept;
            ram_we <= accept & (sel ? req1_we : req0_we);
            if (accept) begin
                c_port    <= sel;
                ram_addr  <= sel ? req1_addr : req0_addr;
                ram_wdata <= sel ? req1_wdata : req0_wdata;
            end
        end
    end

    // Stage R: track the command while the RAM performs the access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld  <= 1'b0;
            r_port <= 1'b0;
        end else begin
            r_vld  <= c_vld;
            r_port <= c_port;
        end
    end

    // Stage O: route RAM output back to the originating port; data holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_rdata <= '0;
        end else begin
            rsp0_valid <= r_vld & ~r_port;
            rsp1_valid <= r_vld & r_port;
            if (r_vld && !r_port) begin
                rsp0_rdata <= ram_rdata;
            end
            if (r_vld && r_port) begin
                rsp1_rdata <= ram_rdata;
            end
        end
    end

endmodule
